// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sc2_block.sv
// sc2_block: one-bit full adder cell producing sum and carry
module sc2_block (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands one bit per clock through a single full-adder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             s, co;

    sc2_block u_cell (
        .s    (s),
        .cout (co),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q)
    );

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

    // next state: shift one bit pair per RUN cycle, accept operands in IDLE/DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sh_d    = {s, sh_q[WIDTH-1:1]};
            carry_d = co;
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                sum_d   = sh_d;
                cout_d  = co;
                state_d = DONE;
            end
        end else if (start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            sh_d    = '0;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    // state and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for the bit-serial adder
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;
    int         checks = 0;
    int         failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] es, input logic ec, input bit inject);
        a = va;
        b = vb;
        cin = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va;
        b = ~vb;
        cin = ~vc;
        for (int i = 0; i < 8; i++) begin
            check("busy_run", 32'(busy), 1);
            check("done_run", 32'(done), 0);
            if (inject && i == 2) begin
                start = 1'b1;
                a = 8'hAA;
                b = 8'h55;
            end
            if (inject && i == 3) start = 1'b0;
            tick();
        end
        check("done_pulse", 32'(done), 1);
        check("busy_done", 32'(busy), 0);
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
    endtask

    task automatic after_done(input logic [7:0] es, input logic ec);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_low", 32'(done), 0);
            check("busy_low", 32'(busy), 0);
            check("sum_hold", 32'(sum), 32'(es));
            check("cout_hold", 32'(cout), 32'(ec));
        end
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_sum", 32'(sum), 0);
            check("rst_cout", 32'(cout), 0);
            tick();
        end

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        after_done(8'h10, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        after_done(8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        after_done(8'hFF, 1'b1);
        run_op(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b0);
        after_done(8'h97, 1'b0);

        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_second_done", 32'(done), 0);
            check("no_queued_busy", 32'(busy), 0);
        end
        check("ignored_sum", 32'(sum), 32'h46);

        a = 8'h80;
        b = 8'h80;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_sum", 32'(sum), 0);
        check("mid_rst_cout", 32'(cout), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_done", 32'(done), 0);
            check("post_rst_busy", 32'(busy), 0);
        end

        reset = 1'b1;
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 0);

        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);
        after_done(8'h04, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder for unsigned WIDTH-bit operands.
- Accepts two operands and a carry-in on a start pulse. Feeds one bit pair per clock, LSB first, through a single one-bit sum/carry cell, and keeps the ripple carry in a flip-flop.
- Publishes the WIDTH-bit sum and the carry-out with a one-cycle done pulse.
- Sits directly upstream of the one-bit cell. It is the sequential wrapper that turns that combinational cell into a multi-bit adder.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A, sampled on the accepting edge only
- b  in  WIDTH  operand B, sampled on the accepting edge only
- cin  in  1  carry-in, sampled on the accepting edge only
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; high while in DONE
- sum  out  WIDTH  result register; updated only on completion
- cout  out  1  final carry-out; updated only on completion

Behaviour:
- Reset: on any edge with reset=1, state goes to IDLE. All of the following clear to 0: busy, done, sum, cout, internal shift registers, carry FF, bit counter. Reset has priority over everything else, including mid-RUN; a partial result is discarded.
- States are IDLE, RUN and DONE.
- busy = (state==RUN) and done = (state==DONE), both Moore outputs with no combinational path from inputs.
- IDLE or DONE with start=1, at edge k:
  - Load a→A_sh, b→B_sh, cin→carry FF.
  - Clear count to 0 and SUM_sh to 0.
  - Go to RUN.
  - a, b and cin are ignored on every other edge.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - Feed the cell with A_sh[0], B_sh[0], carry. The cell produces s and co.
  - Shift A_sh and B_sh right by 1.
  - Shift SUM_sh right by 1, inserting s at the MSB.
  - carry ← co, count ← count+1.
- RUN at the edge where count==WIDTH-1: perform the shift above and also:
  - sum ← the final SUM_sh value, i.e. {s, SUM_sh[WIDTH-1:1]}.
  - cout ← co.
  - Go to DONE.
- Latency: accept at edge k; busy is high for cycles k+1..k+WIDTH; done is high for exactly one cycle after edge k+WIDTH; sum/cout are valid from that same cycle.
- sum and cout hold their value until the next completion or reset. They never show partial values.
- start while busy is ignored and not queued; the operation in flight is unaffected.
- Back-to-back operation: start=1 during DONE is accepted at that edge. The next op's busy follows immediately with no IDLE cycle, and done stays a single-cycle pulse.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- Wrap-around: the all-ones case gives 2^WIDTH-1 + 2^WIDTH-1 + 1 = {1, all-ones}.
- count is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- reset=1 together with start=1: reset wins and start is dropped.

Decomposition:
- Shared package: state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; default WIDTH constant.
- One sub-module: the existing one-bit sum/carry cell, sc2_block, port order (s, cout, a, b, cin). It is instantiated once, with purely combinational use.
- serial_adder contains all sequential logic: FSM, counter, shift registers, carry FF, result registers.

Test Plan:
- Reset then idle: reset=1 for 2 edges, then start=0 for 5 edges → busy=0, done=0, sum=8'h00, cout=0 throughout.
- Basic add: a=8'h0F, b=8'h01, cin=0, start for 1 cycle at edge k → busy high cycles k+1..k+8; done high in cycle k+9 only; sum=8'h10, cout=0 held after.
- Carry wrap: a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Start ignored while busy: accept a=8'h12, b=8'h34. At k+3 assert start with a=8'hAA, b=8'h55 → single done at k+9 with sum=8'h46, cout=0; no second done.
- Reset mid-op: accept a=8'h80, b=8'h80, reset=1 at edge k+4 → busy=0, done=0, sum=0, cout=0 from k+5. No done for 20 further cycles with start=0.
- Back-to-back: hold start=1 during DONE with a=8'h01, b=8'h02, cin=1 → busy in the very next cycle; second done 9 cycles after the first; sum=8'h04, cout=0.
